// File: rtl/biquad8_pkg.sv
// Shared types and helpers for the biquad8 coefficient sequencer.
// Holds the FSM state encoding and the shadow address mapping.
package biquad8_pkg;

    localparam int CW_DEFAULT = 18;

    // ST_NEXT names the target-advance decision; it is taken on the GAP/UPDATE
    // exit edge and never occupies a cycle of its own.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_UPDATE,
        ST_NEXT,
        ST_DONE
    } seq_state_e;

    function automatic int unsigned shadow_adr(input int unsigned tgt,
                                               input int unsigned idx,
                                               input int unsigned ncoeff);
        return tgt * ncoeff + idx;
    endfunction

endpackage

// File: rtl/biquad8_coeff_shadow.sv
// Host-writable shadow register file holding every target's coefficient chain.
// One write port, one combinational read port for the sequencer; resets to zero.
module biquad8_coeff_shadow
    import biquad8_pkg::*;
#(
    parameter int NWORD = 4,
    parameter int CW    = CW_DEFAULT,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_adr_i,
    input  logic [CW-1:0] wr_dat_i,
    input  logic [AW-1:0] rd_adr_i,
    output logic [CW-1:0] rd_dat_o
);

    logic [CW-1:0] mem_q [NWORD];

    // Addresses with no matching word fall through both loops untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORD; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < NWORD; i++) begin
                if (wr_adr_i == AW'(i)) begin
                    mem_q[i] <= wr_dat_i;
                end
            end
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int i = 0; i < NWORD; i++) begin
            if (rd_adr_i == AW'(i)) begin
                rd_dat_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/biquad8_coeff_sequencer.sv
// Coefficient load controller: shifts shadowed chains into up to NTARGET biquad8
// stages over a shared bus, then issues per-target or simultaneous update strobes.
module biquad8_coeff_sequencer
    import biquad8_pkg::*;
#(
    parameter int NCOEFF  = 2,
    parameter int NTARGET = 2,
    parameter int CW      = CW_DEFAULT,
    parameter int AW      = $clog2(NTARGET * NCOEFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_i,
    input  logic [AW-1:0]      adr_i,
    input  logic [CW-1:0]      dat_i,
    input  logic               commit_i,
    input  logic [NTARGET-1:0] mask_i,
    input  logic               sync_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CW-1:0]      coeff_dat_o,
    output logic [NTARGET-1:0] coeff_wr_o,
    output logic [NTARGET-1:0] coeff_update_o
);

    localparam int TW = (NTARGET > 1) ? $clog2(NTARGET) : 1;
    localparam int IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCOEFF - 1);

    seq_state_e         state_q;
    logic [TW-1:0]      tgt_q;
    logic [IW-1:0]      idx_q;
    logic [NTARGET-1:0] rem_q;
    logic [NTARGET-1:0] all_q;
    logic               sync_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [NTARGET-1:0] wr_q;
    logic [NTARGET-1:0] upd_q;
    logic [CW-1:0]      dat_q;

    logic [AW-1:0]      rd_adr;
    logic [CW-1:0]      rd_dat;
    logic [TW-1:0]      cmt_tgt;
    logic [TW-1:0]      nxt_tgt;
    logic               commit_ok;

    function automatic logic [TW-1:0] lowest_idx(input logic [NTARGET-1:0] m);
        logic [TW-1:0] r;
        r = '0;
        for (int i = NTARGET - 1; i >= 0; i--) begin
            if (m[i]) r = TW'(i);
        end
        return r;
    endfunction

    function automatic logic [NTARGET-1:0] tgt_bit(input logic [TW-1:0] t);
        return NTARGET'(1) << t;
    endfunction

    // Commit handshake: commit_i is a one-cycle request, taken only while
    // busy_o is low and mask_i is non-zero; there is no back-pressure, a
    // request or shadow write arriving while busy is dropped and flagged on err_o.
    assign commit_ok = commit_i && !busy_q && (mask_i != '0);
    assign cmt_tgt   = lowest_idx(mask_i);
    assign nxt_tgt   = lowest_idx(rem_q);
    assign rd_adr    = AW'(shadow_adr(32'(tgt_q), 32'(idx_q), NCOEFF));

    biquad8_coeff_shadow #(
        .NWORD (NTARGET * NCOEFF),
        .CW    (CW),
        .AW    (AW)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_i && !busy_q),
        .wr_adr_i (adr_i),
        .wr_dat_i (dat_i),
        .rd_adr_i (rd_adr),
        .rd_dat_o (rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            all_q   <= '0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            upd_q   <= '0;
            dat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            upd_q  <= '0;
            // Target registers its CE, so the word follows its strobe by one cycle.
            dat_q  <= (state_q == ST_LOAD) ? rd_dat : '0;
            if (busy_q && (wr_i || commit_i)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (commit_ok) begin
                        state_q <= ST_LOAD;
                        tgt_q   <= cmt_tgt;
                        idx_q   <= IDX_LAST;
                        rem_q   <= mask_i & ~tgt_bit(cmt_tgt);
                        all_q   <= mask_i;
                        sync_q  <= sync_i;
                        busy_q  <= 1'b1;
                        wr_q    <= tgt_bit(cmt_tgt);
                        err_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (idx_q == '0) begin
                        state_q <= ST_GAP;
                        wr_q    <= '0;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                ST_GAP: begin
                    if (sync_q && (rem_q != '0)) begin
                        state_q <= ST_LOAD;
                        tgt_q   <= nxt_tgt;
                        idx_q   <= IDX_LAST;
                        rem_q   <= rem_q & ~tgt_bit(nxt_tgt);
                        wr_q    <= tgt_bit(nxt_tgt);
                    end else begin
                        state_q <= ST_UPDATE;
                        upd_q   <= sync_q ? all_q : tgt_bit(tgt_q);
                    end
                end
                ST_UPDATE: begin
                    if (!sync_q && (rem_q != '0)) begin
                        state_q <= ST_LOAD;
                        tgt_q   <= nxt_tgt;
                        idx_q   <= IDX_LAST;
                        rem_q   <= rem_q & ~tgt_bit(nxt_tgt);
                        wr_q    <= tgt_bit(nxt_tgt);
                    end else begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign coeff_dat_o    = dat_q;
    assign coeff_wr_o     = wr_q;
    assign coeff_update_o = upd_q;

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// Directed bench for biquad8_coeff_sequencer: per-cycle vector table plus
// hand-written reset and sync-load sequences checked against a target chain model.
module tb_biquad8_coeff_sequencer;

    localparam int NCOEFF  = 2;
    localparam int NTARGET = 2;
    localparam int CW      = 18;
    localparam int AW      = 3;

    logic               clk;
    logic               rst_n;
    logic               wr_i;
    logic [AW-1:0]      adr_i;
    logic [CW-1:0]      dat_i;
    logic               commit_i;
    logic [NTARGET-1:0] mask_i;
    logic               sync_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [CW-1:0]      coeff_dat_o;
    logic [NTARGET-1:0] coeff_wr_o;
    logic [NTARGET-1:0] coeff_update_o;

    int n_cmp  = 0;
    int n_fail = 0;

    biquad8_coeff_sequencer #(
        .NCOEFF  (NCOEFF),
        .NTARGET (NTARGET),
        .CW      (CW),
        .AW      (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_i           (wr_i),
        .adr_i          (adr_i),
        .dat_i          (dat_i),
        .commit_i       (commit_i),
        .mask_i         (mask_i),
        .sync_i         (sync_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- target chain model ----------------
    logic [CW-1:0]      chain [NTARGET][NCOEFF];
    logic [CW-1:0]      b2    [NTARGET][NCOEFF];
    logic [NTARGET-1:0] ce_d;
    int                 upd_cnt;
    int                 onehot_viol;

    initial begin
        for (int t = 0; t < NTARGET; t++) begin
            for (int j = 0; j < NCOEFF; j++) begin
                chain[t][j] = '0;
                b2[t][j]    = '0;
            end
        end
        ce_d        = '0;
        upd_cnt     = 0;
        onehot_viol = 0;
    end

    always @(posedge clk) begin
        for (int t = 0; t < NTARGET; t++) begin
            if (ce_d[t]) begin
                for (int j = NCOEFF - 1; j > 0; j--) chain[t][j] = chain[t][j-1];
                chain[t][0] = coeff_dat_o;
            end
        end
        for (int t = 0; t < NTARGET; t++) begin
            if (coeff_update_o[t]) b2[t] = chain[t];
        end
        if (coeff_update_o != '0) upd_cnt++;
        if ($countones(coeff_wr_o) > 1) onehot_viol++;
        ce_d = coeff_wr_o;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic               wr;
        logic [AW-1:0]      adr;
        logic [CW-1:0]      dat;
        logic               commit;
        logic [NTARGET-1:0] mask;
        logic               sync;
        logic               busy;
        logic               done;
        logic               err;
        logic [CW-1:0]      cdat;
        logic [NTARGET-1:0] cwr;
        logic [NTARGET-1:0] cupd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] adr, input logic [CW-1:0] dat,
                                input logic commit, input logic [NTARGET-1:0] mask, input logic sync,
                                input logic busy, input logic done, input logic err,
                                input logic [CW-1:0] cdat, input logic [NTARGET-1:0] cwr,
                                input logic [NTARGET-1:0] cupd);
        vec_t v;
        v.wr = wr; v.adr = adr; v.dat = dat; v.commit = commit; v.mask = mask; v.sync = sync;
        v.busy = busy; v.done = done; v.err = err; v.cdat = cdat; v.cwr = cwr; v.cupd = cupd;
        return v;
    endfunction

    task automatic drive_idle();
        wr_i = 1'b0; adr_i = '0; dat_i = '0; commit_i = 1'b0; mask_i = '0; sync_i = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic busy, input logic done, input logic err,
                                 input logic [CW-1:0] cdat, input logic [NTARGET-1:0] cwr,
                                 input logic [NTARGET-1:0] cupd);
        check({tag, ".busy"}, 32'(busy_o), 32'(busy));
        check({tag, ".done"}, 32'(done_o), 32'(done));
        check({tag, ".err"},  32'(err_o),  32'(err));
        check({tag, ".dat"},  32'(coeff_dat_o), 32'(cdat));
        check({tag, ".wr"},   32'(coeff_wr_o), 32'(cwr));
        check({tag, ".upd"},  32'(coeff_update_o), 32'(cupd));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int upd_snap;
        bit seen_done;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;

        // wr adr dat cmt mask sync | busy done err cdat cwr cupd
        tbl.push_back(mk(1, 0, 18'h11, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 18'h22, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2, 18'h33, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 3, 18'h44, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        // per-target load of T0
        tbl.push_back(mk(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0,      2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h22, 2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h11, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b00, 2'b01));
        // done cycle doubles as commit of a sync load of both targets
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 1, 0, 1, 0, 0,      2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h22, 2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h11, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h44, 2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h33, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b00, 2'b11));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0,      2'b00, 2'b00));
        // load T1 alone; write + commit while busy are rejected
        tbl.push_back(mk(0, 0, 0,      1, 2'b10, 0, 0, 0, 0, 0,      2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 18'h55, 1, 2'b01, 0, 1, 0, 0, 0,      2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 0,      0, 2'b00, 0, 1, 0, 1, 18'h44, 2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 0,      0, 2'b00, 0, 1, 0, 1, 18'h33, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0,      0, 2'b00, 0, 1, 0, 1, 0,      2'b00, 2'b10));
        tbl.push_back(mk(0, 0, 0,      0, 2'b00, 0, 0, 1, 1, 0,      2'b00, 2'b00));
        // next accepted commit clears err; shadow[0] still holds 0x11
        tbl.push_back(mk(0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 0,      2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h22, 2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h11, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b00, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0,      2'b00, 2'b00));
        // empty-mask commit and out-of-range write are both ignored
        tbl.push_back(mk(1, 4, 18'h77, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0,      0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0,      0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0,      2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h22, 2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h11, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b00, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h44, 2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 18'h33, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0,      2'b00, 2'b10));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0,      2'b00, 2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            check_outputs($sformatf("row%0d", i), tbl[i].busy, tbl[i].done, tbl[i].err,
                          tbl[i].cdat, tbl[i].cwr, tbl[i].cupd);
            wr_i = tbl[i].wr; adr_i = tbl[i].adr; dat_i = tbl[i].dat;
            commit_i = tbl[i].commit; mask_i = tbl[i].mask; sync_i = tbl[i].sync;
        end
        @(negedge clk);
        drive_idle();

        check("b2_t0_0", 32'(b2[0][0]), 32'h11);
        check("b2_t0_1", 32'(b2[0][1]), 32'h22);
        check("b2_t1_0", 32'(b2[1][0]), 32'h33);
        check("b2_t1_1", 32'(b2[1][1]), 32'h44);

        // reset in cycle 3 of a per-target mask=11 load
        upd_snap = upd_cnt;
        @(negedge clk);
        commit_i = 1'b1; mask_i = 2'b11; sync_i = 1'b0;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check("pre_rst.dat", 32'(coeff_dat_o), 32'h11);
        rst_n = 1'b0;
        #1;
        check_outputs("in_rst", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.no_update", 32'(upd_cnt), 32'(upd_snap));
        check("rst.b2_t0_1", 32'(b2[0][1]), 32'h22);
        check("rst.b2_t1_0", 32'(b2[1][0]), 32'h33);

        // sync reload after reset pushes the cleared shadow into both targets
        commit_i = 1'b1; mask_i = 2'b11; sync_i = 1'b1;
        @(negedge clk);
        drive_idle();
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("sync_done_seen", 32'(seen_done), 32'd1);
        check("zero.b2_t0_0", 32'(b2[0][0]), 32'h0);
        check("zero.b2_t0_1", 32'(b2[0][1]), 32'h0);
        check("zero.b2_t1_0", 32'(b2[1][0]), 32'h0);
        check("zero.b2_t1_1", 32'(b2[1][1]), 32'h0);
        check("update_pulses", 32'(upd_cnt), 32'(upd_snap + 1));
        check("wr_onehot", 32'(onehot_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
